// File: rtl/ave8_inv.sv
// Inverse moving-sum averager: rebuilds x[n] = S[n] - S[n-1] + x[n-8] from the 11-bit window sum, one sample per 3-cycle frame.
// Result registered two edges after the sum is captured; no backpressure, sums offered outside S_CAP are dropped and flag overrun.
module ave8_inv #(
    parameter int DEPTH = 8,
    parameter int SUM_W = 11,
    parameter int X_W   = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic [X_W-1:0]   x_out,
    output logic             x_valid,
    output logic [1:0]       err
);

    // Two extra bits hold the exact signed range of S - S_prev + x_old.
    localparam int D_W = SUM_W + 2;

    typedef enum logic [1:0] {
        S_CAP  = 2'd0,
        S_CALC = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SUM_W-1:0]      s_reg;
    logic [SUM_W-1:0]      prev_sum;
    logic [X_W-1:0]        hist [DEPTH];
    logic signed [D_W-1:0] d_reg;
    logic signed [D_W-1:0] d_calc;

    logic                  d_neg;
    logic                  d_over;
    logic                  d_range_err;
    logic [X_W-1:0]        d_clamp;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_CAP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_CAP;
        case (state_q)
            S_CAP:   state_d = sum_valid ? S_CALC : S_CAP;
            S_CALC:  state_d = S_UPD;
            S_UPD:   state_d = S_CAP;
            default: state_d = S_CAP;
        endcase
    end

    // hist[DEPTH-1] is read here before the shift in S_UPD of the same frame.
    assign d_calc = $signed({{(D_W-SUM_W){1'b0}}, s_reg})
                  - $signed({{(D_W-SUM_W){1'b0}}, prev_sum})
                  + $signed({{(D_W-X_W){1'b0}}, hist[DEPTH-1]});

    assign d_neg       = d_reg[D_W-1];
    assign d_over      = !d_neg && (d_reg[D_W-2:X_W] != '0);
    assign d_range_err = d_neg || d_over;

    always_comb begin
        d_clamp = d_reg[X_W-1:0];
        if (d_neg) begin
            d_clamp = '0;
        end else if (d_over) begin
            d_clamp = '1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            s_reg    <= '0;
            prev_sum <= '0;
            d_reg    <= '0;
            x_out    <= '0;
            x_valid  <= 1'b0;
            err      <= 2'b00;
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            x_valid <= 1'b0;
            case (state_q)
                S_CAP: begin
                    if (sum_valid) begin
                        s_reg <= sum_in;
                    end
                end
                S_CALC: begin
                    d_reg <= d_calc;
                    if (sum_valid) begin
                        err[1] <= 1'b1;
                    end
                end
                S_UPD: begin
                    x_out    <= d_clamp;
                    x_valid  <= 1'b1;
                    prev_sum <= s_reg;
                    for (int i = DEPTH-1; i > 0; i--) begin
                        hist[i] <= hist[i-1];
                    end
                    hist[0] <= d_clamp;
                    if (d_range_err) begin
                        err[0] <= 1'b1;
                    end
                    if (sum_valid) begin
                        err[1] <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ave8_inv.sv
module tb_ave8_inv;

    logic        CLOCK;
    logic        RESET;
    logic [10:0] sum_in;
    logic        sum_valid;
    logic [7:0]  x_out;
    logic        x_valid;
    logic [1:0]  err;

    int n_checks;
    int n_errors;

    ave8_inv dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .x_out     (x_out),
        .x_valid   (x_valid),
        .err       (err)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET     = 1'b1;
        sum_valid = 1'b0;
        sum_in    = '0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_x_valid", int'(x_valid), 0);
        chk("rst_err", int'(err), 0);
    endtask

    // One frame: sum offered for a single cycle, x_valid must appear exactly
    // in the cycle after S_UPD (two edges after the capture edge) and last one cycle.
    task automatic frame(input string tag, input int s, input int exp_x, input int exp_err);
        @(negedge CLOCK);
        sum_in    = 11'(s);
        sum_valid = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        sum_valid = 1'b0;
        chk({tag, "_vld_c1"}, int'(x_valid), 0);
        @(negedge CLOCK);
        chk({tag, "_vld_c2"}, int'(x_valid), 0);
        @(negedge CLOCK);
        chk({tag, "_vld"}, int'(x_valid), 1);
        chk({tag, "_x"}, int'(x_out), exp_x);
        chk({tag, "_err"}, int'(err), exp_err);
        @(negedge CLOCK);
        chk({tag, "_vld_drop"}, int'(x_valid), 0);
        chk({tag, "_x_hold"}, int'(x_out), exp_x);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        RESET     = 1'b1;
        sum_valid = 1'b0;
        sum_in    = '0;

        // Basic differencing
        do_reset();
        frame("basic0", 10, 10, 0);
        frame("basic1", 30, 20, 0);

        // Constant input; frames 9 and 10 depend on the x[n-8] term
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            frame($sformatf("const%0d", k), (k <= 8) ? 100 * k : 800, 100, 0);
        end

        // Range high, then an in-range sum that hits the ceiling exactly
        do_reset();
        frame("hi0", 300, 255, 1);
        frame("hi1", 555, 255, 1);

        // Range low: 20 - 50 = -30 saturates to 0
        do_reset();
        frame("lo0", 50, 50, 0);
        frame("lo1", 20, 0, 1);

        // Overrun: valid held for a second cycle with a different sum
        do_reset();
        @(negedge CLOCK);
        sum_in    = 11'd40;
        sum_valid = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        sum_in = 11'd99;
        chk("ovr_err_before", int'(err), 0);
        @(posedge CLOCK);
        @(negedge CLOCK);
        sum_valid = 1'b0;
        chk("ovr_err_flag", int'(err), 2);
        chk("ovr_vld_c2", int'(x_valid), 0);
        @(negedge CLOCK);
        chk("ovr_vld", int'(x_valid), 1);
        chk("ovr_x", int'(x_out), 40);
        chk("ovr_err", int'(err), 2);
        @(negedge CLOCK);
        chk("ovr_vld_drop", int'(x_valid), 0);
        frame("ovr_next", 140, 100, 2);

        // Reset while the frame is in S_CALC
        do_reset();
        @(negedge CLOCK);
        sum_in    = 11'd77;
        sum_valid = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        sum_valid = 1'b0;
        RESET     = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        chk("mid_vld0", int'(x_valid), 0);
        chk("mid_x", int'(x_out), 0);
        chk("mid_err", int'(err), 0);
        @(negedge CLOCK);
        chk("mid_vld1", int'(x_valid), 0);
        @(negedge CLOCK);
        chk("mid_vld2", int'(x_valid), 0);
        frame("mid_next", 5, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete within bound");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
